// File: rtl/arbitro_rr.sv
// Round-robin router: drains N_IN source FIFOs into N_OUT class-selected destinations, one word per cycle.
// Registered Pop/Push (1 clock head->Push); sources whose destination is almost full are skipped, never blocking others.
module arbitro_rr #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int DATA_W = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Enable,
  input  logic [N_IN-1:0]        FIFO_empty,
  input  logic [N_IN*DATA_W-1:0] FIFO_data,
  input  logic [N_OUT-1:0]       Almost_full,
  output logic [N_IN-1:0]        Pop,
  output logic [N_OUT-1:0]       Push,
  output logic [DATA_W-1:0]      data_out,
  output logic [15:0]            Count,
  output logic                   Idle
);

  localparam int CLASS_W = $clog2(N_OUT);
  localparam int PTR_W   = $clog2(N_IN);
  localparam int DIST_W  = PTR_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_IN-1:0]    pop_q, pop_d;
  logic [N_OUT-1:0]   push_q, push_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [15:0]        count_q, count_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   last_q, last_d;
  logic               last_vld_q, last_vld_d;

  logic [DATA_W-1:0]  head_dat [N_IN];
  logic [CLASS_W-1:0] head_cls [N_IN];
  logic [N_IN-1:0]    elig;

  // The last-granted source is masked because its head only advances one edge after the pop.
  for (genvar i = 0; i < N_IN; i++) begin : g_src
    assign head_dat[i] = FIFO_data[i*DATA_W +: DATA_W];
    assign head_cls[i] = head_dat[i][DATA_W-1 -: CLASS_W];
    assign elig[i]     = ~FIFO_empty[i] & ~Almost_full[head_cls[i]]
                         & ~(last_vld_q && (last_q == PTR_W'(i)));
  end

  logic               gnt_vld;
  logic [PTR_W-1:0]   gnt_idx;
  logic [CLASS_W-1:0] gnt_cls;
  logic [DATA_W-1:0]  gnt_dat;
  logic [DIST_W-1:0]  gnt_dist;
  logic [DIST_W-1:0]  scan_dist;

  // Winner is the eligible source at the smallest circular distance from ptr.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    gnt_cls   = '0;
    gnt_dat   = '0;
    gnt_dist  = '0;
    scan_dist = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (PTR_W'(i) >= ptr_q) begin
        scan_dist = DIST_W'(i) - DIST_W'(ptr_q);
      end else begin
        scan_dist = DIST_W'(i) + DIST_W'(N_IN) - DIST_W'(ptr_q);
      end
      if (elig[i] && (!gnt_vld || (scan_dist < gnt_dist))) begin
        gnt_vld  = 1'b1;
        gnt_idx  = PTR_W'(i);
        gnt_cls  = head_cls[i];
        gnt_dat  = head_dat[i];
        gnt_dist = scan_dist;
      end
    end
  end

  always_comb begin
    pop_d      = '0;
    push_d     = '0;
    data_d     = data_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    last_vld_d = 1'b0;
    last_d     = last_q;
    if (gnt_vld) begin
      pop_d      = N_IN'(1) << gnt_idx;
      push_d     = N_OUT'(1) << gnt_cls;
      data_d     = gnt_dat;
      count_d    = count_q + 16'd1;
      ptr_d      = (gnt_idx == PTR_W'(N_IN - 1)) ? '0 : gnt_idx + PTR_W'(1);
      last_vld_d = 1'b1;
      last_d     = gnt_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_vld)  state_d = ST_BUSY;
      ST_BUSY: if (!gnt_vld) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pop_q      <= '0;
      push_q     <= '0;
      data_q     <= '0;
      count_q    <= '0;
      ptr_q      <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (Enable) begin
      state_q    <= state_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      data_q     <= data_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign Pop      = pop_q;
  assign Push     = push_q;
  assign data_out = data_q;
  assign Count    = count_q;
  assign Idle     = (state_q == ST_IDLE);

endmodule

// File: doc/arbitro_rr.md
# arbitro_rr

Parametrised round-robin router/arbiter for the transaction layer. It drains `N_IN` source FIFOs and steers each word to one of `N_OUT` destination FIFOs, selected by the class field carried in the word. It replaces the single-source, fixed-4-output arbiter: multiple sources are served fairly, and back-pressure is applied per destination instead of globally. It sits between the input FIFO bank and the per-class output FIFO bank.

## Interface
Parameters:
- `N_IN`, 4, number of source FIFOs (2..8)
- `N_OUT`, 4, number of destination FIFOs, power of two (2..8)
- `DATA_W`, 6, word width; class field = top `CLASS_W` bits
- `CLASS_W` (localparam), clog2(`N_OUT`)

Ports:
- `clk`  in  1  clock; all logic on posedge
- `reset`  in  1  synchronous, active-low; one clock, reset is synchronous and active-low
- `Enable`  in  1  1 = arbitrate; 0 = freeze all state and outputs
- `FIFO_empty`  in  `N_IN`  per-source empty flag
- `FIFO_data`  in  `N_IN*DATA_W`  head word of each source (first-word-fall-through); source i at bits [i*DATA_W +: DATA_W]
- `Almost_full`  in  `N_OUT`  per-destination almost-full flag
- `Pop`  out  `N_IN`  one-hot/zero pop strobe to sources
- `Push`  out  `N_OUT`  one-hot/zero push strobe to destinations
- `data_out`  out  `DATA_W`  word accompanying `Push`
- `Count`  out  16  total words routed, wraps at 2^16
- `Idle`  out  1  1 when no source is eligible this cycle

## Operation
- Reset (`reset`=0 at posedge, regardless of `Enable`): `Pop`=0, `Push`=0, `data_out`=0, `Count`=0, `Idle`=1, grant pointer `ptr`=0, `last`=none.
- `Enable`=0: all registers hold their values, including `Pop`/`Push`. Integration must keep `Enable` high during traffic.
- Source i is eligible when all of the following hold:
  - `FIFO_empty[i]`=0;
  - `Almost_full[dest_i]`=0, where dest_i = class field of source i's head;
  - i != `last`.
- Grant: the first eligible index scanning `ptr`, `ptr`+1, … modulo `N_IN`.
- On a grant to g at a posedge:
  - `Pop`=onehot(g), `Push`=onehot(dest_g), `data_out`=head of g;
  - `Count`+=1 (wrapping);
  - `ptr`=(g+1) mod `N_IN`; `last`=g; `Idle`=0.
- No eligible source: `Pop`=0, `Push`=0, `data_out` holds, `ptr` holds, `last`=none, `Idle`=1.
- The `last` mask exists because `Pop` is registered. The source's head and empty flag update one edge after the pop, so the same source is never granted on consecutive cycles.
- Blocking is per destination only. A source whose destination is almost full is skipped; it does not block other sources (no head-of-line blocking across sources).
- States: two-state FSM.
  - IDLE (`Idle`=1): go to BUSY on any grant.
  - BUSY: stay on grant, go to IDLE on no grant.
  - Reset forces IDLE.

## Timing
- One decision per cycle. Word presented by source at edge k appears on `data_out` with `Push` during cycle k..k+1. The destination writes it at edge k+1, the same edge the source pops.
- Latency source head → `Push`: 1 clock.
- Throughput: 1 word/cycle with ≥2 eligible sources; 1 word per 2 cycles with a single active source.
- `Almost_full` is sampled one cycle stale. Destination FIFO threshold must leave ≥2 free entries.
- Reset asserted mid-transfer: `Pop`/`Push` clear at that edge; the in-flight word is still written and popped downstream at that edge (handshake is atomic).
- `Pop` and `Push` are always both zero or both one-hot; never mixed.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with all sources non-empty → `Pop`=0, `Push`=0, `Count`=0, `Idle`=1; first grant after release goes to source 0.
- Fairness: all 4 sources non-empty, classes 0,1,2,3, no almost-full → grants 0,1,2,3,0… each cycle; `Push`=0001,0010,0100,1000; `Count` increments by 1 per cycle.
- Single source: only source 2 non-empty, class 3 → `Pop`=0100 / `Push`=1000 on alternating cycles, `Idle` toggling.
- Per-destination back-pressure: `Almost_full`=0010, sources 0 (class 1) and 1 (class 2) non-empty → only source 1 granted; source 0 granted the cycle after `Almost_full[1]` drops.
- `Enable`=0 mid-stream with `Pop`=0010 → outputs and `Count` frozen; on resume, arbitration continues from the stored `ptr`.
- Wrap: preload by running 65536 transfers → `Count` returns to 0; `Pop`/`Push` never both nonzero with differing popcount.
